// File: rtl/cr_tcipif_initiator.sv
// Single-outstanding tcipif initiator: core valid/ready request in, one-hot slave access, buffered response out.
// Optional wait-cycle timeout is compiled in with `define CR_TCIPIF_TIMEOUT_EN.
module cr_tcipif_initiator #(
  parameter int NSLV = 4,
  parameter int TO_W = 8
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic [15:0]          req_addr,
  input  logic                 req_write,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_vld,
  input  logic                 rsp_rdy,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [NSLV-1:0]      tcipif_x_sel,
  output logic [15:0]          tcipif_x_addr,
  output logic                 tcipif_x_write,
  output logic [31:0]          tcipif_x_wdata,
  input  logic [NSLV-1:0]      x_tcipif_cmplt,
  input  logic [32*NSLV-1:0]   x_tcipif_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state;
  logic [NSLV-1:0] dec_sel;
  logic            dec_hit;
  logic            cmplt_hit;
  logic [31:0]     rdata_mux;

  // The slave index is a 4-bit address nibble, so at most 16 responders decode.
  if (NSLV < 1 || NSLV > 16 || TO_W < 2) begin : g_param_check
    $error("cr_tcipif_initiator: NSLV must be 1..16 and TO_W at least 2");
  end

`ifdef CR_TCIPIF_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_PRE = {{(TO_W-1){1'b1}}, 1'b0};
  logic [TO_W-1:0] wait_cnt;

  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
`endif

  always_comb begin
    dec_sel = '0;
    for (int i = 0; i < NSLV; i++)
      dec_sel[i] = (req_addr[15:12] == 4'(i));
    dec_hit = |dec_sel;
  end

  // The registered one-hot select doubles as the latched slave index.
  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < NSLV; i++)
      if (tcipif_x_sel[i]) rdata_mux = rdata_mux | x_tcipif_rdata[32*i +: 32];
    cmplt_hit = |(x_tcipif_cmplt & tcipif_x_sel);
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state          <= IDLE;
      req_rdy        <= 1'b1;
      rsp_vld        <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_rdata      <= '0;
      tcipif_x_sel   <= '0;
      tcipif_x_addr  <= '0;
      tcipif_x_write <= 1'b0;
      tcipif_x_wdata <= '0;
`ifdef CR_TCIPIF_TIMEOUT_EN
      wait_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_vld) begin
            tcipif_x_addr  <= req_addr;
            tcipif_x_write <= req_write;
            tcipif_x_wdata <= req_wdata;
            req_rdy        <= 1'b0;
`ifdef CR_TCIPIF_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
            if (dec_hit) begin
              tcipif_x_sel <= dec_sel;
              state        <= ACCESS;
            end else begin
              rsp_vld   <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RESP;
            end
          end
        end
        ACCESS: begin
          // Completion is checked first so it wins over a coincident timeout.
          if (cmplt_hit) begin
            rsp_rdata    <= tcipif_x_write ? 32'h0 : rdata_mux;
            rsp_err      <= 1'b0;
            rsp_vld      <= 1'b1;
            tcipif_x_sel <= '0;
            state        <= RESP;
          end
`ifdef CR_TCIPIF_TIMEOUT_EN
          else begin
            wait_cnt <= sat_inc(wait_cnt);
            if (wait_cnt >= TO_PRE) begin
              rsp_rdata    <= '0;
              rsp_err      <= 1'b1;
              rsp_vld      <= 1'b1;
              tcipif_x_sel <= '0;
              state        <= RESP;
            end
          end
`endif
        end
        RESP: begin
          if (rsp_rdy) begin
            rsp_vld <= 1'b0;
            req_rdy <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cr_tcipif_initiator.sv
// Bench for cr_tcipif_initiator: directed vector table, hand sequences for stall/timeout/reset,
// and random transactions checked against a transaction-level model.
module tb_cr_tcipif_initiator;
  localparam int NSLV   = 4;
  localparam int TO_W   = 4;
  localparam int TO_LIM = (1 << TO_W) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_vld, req_rdy, req_write;
  logic [15:0]         req_addr;
  logic [31:0]         req_wdata;
  logic                rsp_vld, rsp_rdy, rsp_err;
  logic [31:0]         rsp_rdata;
  logic [NSLV-1:0]     sel, cmplt, noise;
  logic [15:0]         x_addr;
  logic                x_write;
  logic [31:0]         x_wdata;
  logic [32*NSLV-1:0]  rdata_bus;
  logic [31:0]         slice [NSLV];
  int                  slv_delay;
  logic                slv_never;
  int                  busy_cnt = 0;
  int                  total = 0;
  int                  bad = 0;

  typedef struct {
    logic [15:0] addr;
    logic        write;
    logic [31:0] wdata;
    int          delay;
    int          hold;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          selc;
  } vec_t;

  always #5 clk = ~clk;

  cr_tcipif_initiator #(.NSLV(NSLV), .TO_W(TO_W)) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_addr       (req_addr),
    .req_write      (req_write),
    .req_wdata      (req_wdata),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .tcipif_x_sel   (sel),
    .tcipif_x_addr  (x_addr),
    .tcipif_x_write (x_write),
    .tcipif_x_wdata (x_wdata),
    .x_tcipif_cmplt (cmplt),
    .x_tcipif_rdata (rdata_bus)
  );

  // Responder model: completes combinationally once selected for slv_delay cycles;
  // unselected completion lines carry random noise.
  always @(posedge clk) busy_cnt <= (sel != '0) ? busy_cnt + 1 : 0;

  always_comb begin
    rdata_bus = '0;
    cmplt     = '0;
    for (int i = 0; i < NSLV; i++) begin
      rdata_bus[32*i +: 32] = slice[i];
      cmplt[i] = sel[i] ? (!slv_never && busy_cnt >= slv_delay) : noise[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Transaction-level expectation: decode miss -> immediate error; otherwise the slave
  // is selected delay+1 cycles and the response follows one cycle later.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int idx = int'(v.addr[15:12]);
    r.err   = (idx >= NSLV);
    r.rdata = (r.err || v.write) ? 32'h0 : slice[idx];
    r.selc  = r.err ? 0 : v.delay + 1;
    r.lat   = r.selc + 1;
`ifdef CR_TCIPIF_TIMEOUT_EN
    if (!r.err && r.selc > TO_LIM) begin
      r.err   = 1'b1;
      r.rdata = 32'h0;
      r.selc  = TO_LIM;
      r.lat   = TO_LIM + 1;
    end
`endif
    return r;
  endfunction

  task automatic do_txn(input vec_t v);
    logic [NSLV-1:0] exp_sel;
    logic [31:0]     rd0;
    logic            e0;
    int              k, sc;
    bit              got, sel_bad, bus_bad, hold_bad;
    exp_sel = '0;
    if (int'(v.addr[15:12]) < NSLV) exp_sel[v.addr[1:0] & 2'b00 | v.addr[13:12]] = 1'b1;
    slv_delay = v.delay;
    @(negedge clk);
    req_vld = 1'b1; req_addr = v.addr; req_write = v.write; req_wdata = v.wdata;
    chk("req_rdy_idle", {31'b0, req_rdy}, 32'd1);
    k = 0; sc = 0; got = 0; sel_bad = 0; bus_bad = 0;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      noise = NSLV'($urandom);
      if (k == 1) req_vld = 1'b0;
      if (rsp_vld) got = 1;
      else if (sel != '0) begin
        sc++;
        if (sel !== exp_sel) sel_bad = 1;
        if (x_addr !== v.addr || x_write !== v.write || x_wdata !== v.wdata) bus_bad = 1;
      end
    end
    chk("rsp_seen", {31'b0, got}, 32'd1);
    chk("latency", k, v.lat);
    chk("sel_cycles", sc, v.selc);
    chk("sel_onehot", {31'b0, sel_bad}, 32'd0);
    chk("bus_stable", {31'b0, bus_bad}, 32'd0);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, v.err});
    chk("rsp_rdata", rsp_rdata, v.rdata);
    chk("sel_low_in_resp", {28'b0, sel}, 32'd0);
    rd0 = rsp_rdata; e0 = rsp_err; hold_bad = 0;
    for (int h = 0; h < v.hold; h++) begin
      req_vld = 1'b1; req_addr = 16'h1000;
      @(negedge clk);
      if (!rsp_vld || rsp_rdata !== rd0 || rsp_err !== e0 || req_rdy !== 1'b0 || sel !== '0)
        hold_bad = 1;
    end
    if (v.hold > 0) chk("hold_stable", {31'b0, hold_bad}, 32'd0);
    req_vld = 1'b0; rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    chk("rsp_vld_clr", {31'b0, rsp_vld}, 32'd0);
    chk("req_rdy_back", {31'b0, req_rdy}, 32'd1);
    chk("no_accept", {28'b0, sel}, 32'd0);
  endtask

  // Asserts reset mid-cycle while an access is in flight and checks the asynchronous drop.
  task automatic reset_mid();
    #2 rst = 1'b1;
    #1;
    chk("rst_sel", {28'b0, sel}, 32'd0);
    chk("rst_rsp_vld", {31'b0, rsp_vld}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_rdy", {31'b0, req_rdy}, 32'd1);
    chk("rst_idle_sel", {28'b0, sel}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [8];
    vec_t v;
    bit   stall_bad;
    rst = 1'b1; req_vld = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    rsp_rdy = 1'b0; slv_never = 1'b0; slv_delay = 0; noise = '0;
    slice[0] = 32'hA5A5_0000; slice[1] = 32'h00FF_1234;
    slice[2] = 32'h2222_2222; slice[3] = 32'h3333_3333;

    //          addr      wr    wdata          dly hold err   rdata          lat selc
    tbl[0] = '{16'h1014, 1'b0, 32'hDEAD_0001, 0,  0,   1'b0, 32'h00FF_1234, 2,  1};
    tbl[1] = '{16'h0010, 1'b1, 32'h0000_0007, 3,  0,   1'b0, 32'h0000_0000, 5,  4};
    tbl[2] = '{16'h5000, 1'b0, 32'h1111_0000, 0,  0,   1'b1, 32'h0000_0000, 1,  0};
    tbl[3] = '{16'h3FFC, 1'b0, 32'h0BAD_CAFE, 1,  5,   1'b0, 32'h3333_3333, 3,  2};
    tbl[4] = '{16'hF000, 1'b1, 32'hFFFF_FFFF, 0,  2,   1'b1, 32'h0000_0000, 1,  0};
    tbl[5] = '{16'h2000, 1'b0, 32'h0000_0000, 0,  5,   1'b0, 32'h2222_2222, 2,  1};
    tbl[6] = '{16'h0ABC, 1'b0, 32'h1234_5678, 2,  0,   1'b0, 32'hA5A5_0000, 4,  3};
    tbl[7] = '{16'h2004, 1'b1, 32'h8000_0001, 0,  1,   1'b0, 32'h0000_0000, 2,  1};

    @(negedge clk);
    @(negedge clk);
    chk("reset_req_rdy", {31'b0, req_rdy}, 32'd1);
    chk("reset_rsp_vld", {31'b0, rsp_vld}, 32'd0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_sel", {28'b0, sel}, 32'd0);
    chk("reset_addr", {16'b0, x_addr}, 32'd0);
    chk("reset_write", {31'b0, x_write}, 32'd0);
    chk("reset_wdata", x_wdata, 32'd0);
    rst = 1'b0;

    for (int n = 0; n < 8; n++) do_txn(tbl[n]);

`ifdef CR_TCIPIF_TIMEOUT_EN
    slv_never = 1'b1;
    v = '{16'h2000, 1'b0, 32'h0, 0, 1, 1'b1, 32'h0, TO_LIM + 1, TO_LIM};
    do_txn(v);
    slv_never = 1'b0;
    v = '{16'h2008, 1'b0, 32'h0, TO_LIM - 1, 0, 1'b0, 32'h2222_2222, TO_LIM + 1, TO_LIM};
    do_txn(v);
    slv_never = 1'b1;
    @(negedge clk);
    req_vld = 1'b1; req_addr = 16'h1000; req_write = 1'b0;
    repeat (3) @(negedge clk);
    req_vld = 1'b0;
    chk("pre_reset_sel", {28'b0, sel}, 32'h2);
    reset_mid();
`else
    slv_never = 1'b1;
    @(negedge clk);
    req_vld = 1'b1; req_addr = 16'h2000; req_write = 1'b0;
    @(negedge clk);
    req_vld = 1'b0;
    stall_bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (sel !== 4'b0100 || rsp_vld !== 1'b0) stall_bad = 1;
      @(negedge clk);
    end
    chk("stall_100", {31'b0, stall_bad}, 32'd0);
    reset_mid();
`endif
    slv_never = 1'b0;
    do_txn(tbl[0]);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NSLV; i++) slice[i] = $urandom;
      v.addr  = {4'($urandom_range(0, 5)), 12'($urandom)};
      v.write = 1'($urandom);
      v.wdata = $urandom;
      v.delay = $urandom_range(0, 5);
      v.hold  = $urandom_range(0, 3);
      do_txn(model(v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
